// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating signed accumulator for runs of multiplier products
// Sums iLen products over a valid/ready handshake and holds the result until accepted.
module mac_accumulator #(
  parameter int PRODUCT_LENGTH = 32,
  parameter int ACC_LENGTH     = 40,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iStart,
  input  logic [COUNT_WIDTH-1:0]    iLen,
  input  logic [PRODUCT_LENGTH-1:0] iProduct,
  input  logic                      iProdValid,
  output logic                      oProdReady,
  output logic [ACC_LENGTH-1:0]     oAcc,
  output logic                      oAccValid,
  input  logic                      iAccReady,
  output logic                      oBusy,
  output logic                      oOverflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state, state_next;
  logic [ACC_LENGTH-1:0]  acc, acc_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic                   overflow, overflow_next;
  logic [ACC_LENGTH:0]    sum;
  logic [ACC_LENGTH-1:0]  sum_sat;
  logic                   sat_hit;

  // One extra bit catches overflow: top two bits disagree only when the true sum left the range.
  always_comb begin
    sum = {acc[ACC_LENGTH-1], acc}
        + {{(ACC_LENGTH - PRODUCT_LENGTH + 1){iProduct[PRODUCT_LENGTH-1]}}, iProduct};
    sat_hit = sum[ACC_LENGTH] ^ sum[ACC_LENGTH-1];
    if (!sat_hit) begin
      sum_sat = sum[ACC_LENGTH-1:0];
    end else if (sum[ACC_LENGTH]) begin
      sum_sat = {1'b1, {(ACC_LENGTH-1){1'b0}}};
    end else begin
      sum_sat = {1'b0, {(ACC_LENGTH-1){1'b1}}};
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    count_next    = count;
    overflow_next = overflow;
    oProdReady    = 1'b0;
    oAccValid     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          acc_next      = '0;
          count_next    = iLen;
          overflow_next = 1'b0;
          // An empty run goes straight to DONE with a zero result.
          state_next    = (iLen == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        oProdReady = 1'b1;
        if (iProdValid) begin
          acc_next   = sum_sat;
          count_next = count - COUNT_WIDTH'(1);
          if (sat_hit) begin
            overflow_next = 1'b1;
          end
          if (count == COUNT_WIDTH'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        oAccValid = 1'b1;
        if (iAccReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign oAcc      = acc;
  assign oOverflow = overflow;
  assign oBusy     = (state != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator at 40-bit and 33-bit widths
// Both instances share stimulus; a longint reference model predicts each result.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len_in;
  logic [31:0] product;
  logic        prod_valid;
  logic        acc_ready;

  logic        ready40, accv40, busy40, ovf40;
  logic [39:0] acc40;
  logic        ready33, accv33, busy33, ovf33;
  logic [32:0] acc33;

  int checks   = 0;
  int failures = 0;

  int     prods[$];
  longint exp40_q[$];
  longint exp33_q[$];
  bit     ov40_q[$];
  bit     ov33_q[$];

  always #5 clk = ~clk;

  mac_accumulator #(.PRODUCT_LENGTH(32), .ACC_LENGTH(40), .COUNT_WIDTH(8)) u_dut40 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iLen(len_in),
    .iProduct(product), .iProdValid(prod_valid), .oProdReady(ready40),
    .oAcc(acc40), .oAccValid(accv40), .iAccReady(acc_ready),
    .oBusy(busy40), .oOverflow(ovf40)
  );

  mac_accumulator #(.PRODUCT_LENGTH(32), .ACC_LENGTH(33), .COUNT_WIDTH(8)) u_dut33 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iLen(len_in),
    .iProduct(product), .iProdValid(prod_valid), .oProdReady(ready33),
    .oAcc(acc33), .oAccValid(accv33), .iAccReady(acc_ready),
    .oBusy(busy33), .oOverflow(ovf33)
  );

  task automatic sat_add(inout longint m, inout bit o, input longint p, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    m = m + p;
    if (m > mx) begin
      m = mx; o = 1'b1;
    end else if (m < mn) begin
      m = mn; o = 1'b1;
    end
  endtask

  // Runs one transaction from prods[], pushes the model result, returns negedges from start to result.
  task automatic drive_run(input int len, input int gap, output int cycles);
    longint m40, m33;
    bit     o40, o33;
    int     n;
    m40 = 0; m33 = 0; o40 = 1'b0; o33 = 1'b0;
    start  = 1'b1;
    len_in = 8'(len);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          cycles++;
        end
      end
      prod_valid = 1'b1;
      product    = prods[i];
      n = 0;
      while (!ready40 && n < 16) begin
        @(negedge clk);
        cycles++;
        n++;
      end
      @(negedge clk);
      cycles++;
      prod_valid = 1'b0;
      sat_add(m40, o40, longint'(prods[i]), 40);
      sat_add(m33, o33, longint'(prods[i]), 33);
    end
    n = 0;
    while (!accv40 && n < 600) begin
      @(negedge clk);
      cycles++;
      n++;
    end
    exp40_q.push_back(m40);
    exp33_q.push_back(m33);
    ov40_q.push_back(o40);
    ov33_q.push_back(o33);
  endtask

  task automatic accept();
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy40, ready40, accv40, ovf40, acc40} !== 44'd0) begin
      failures++; $display("FAIL reset_init40: got %h expected 0", {busy40, ready40, accv40, ovf40, acc40});
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; len_in = 8'd5;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; product = 32'd11;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if ({busy40, ready40, accv40, ovf40, acc40} !== 44'd0) begin
      failures++; $display("FAIL reset_mid40: got %h expected 0", {busy40, ready40, accv40, ovf40, acc40});
    end
    if ({busy33, ready33, accv33, ovf33, acc33} !== 37'd0) begin
      failures++; $display("FAIL reset_mid33: got %h expected 0", {busy33, ready33, accv33, ovf33, acc33});
    end
    @(negedge clk);
    rst_n = 1'b1; prod_valid = 1'b0;
    @(negedge clk);
    prods = '{7, -3};
    drive_run(2, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 4;
    if (accv40 !== 1'b1) begin failures++; $display("FAIL reset_run_valid: got %b expected 1", accv40); end
    if (acc40 !== e40[39:0]) begin failures++; $display("FAIL reset_run_acc40: got %h expected %h", acc40, e40[39:0]); end
    if (acc33 !== e33[32:0]) begin failures++; $display("FAIL reset_run_acc33: got %h expected %h", acc33, e33[32:0]); end
    if ({ovf40, ovf33} !== {o40, o33}) begin failures++; $display("FAIL reset_run_ovf: got %b%b expected %b%b", ovf40, ovf33, o40, o33); end
    accept();
  endtask

  task automatic test_basic();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    prods = '{100, -250, 30000, -7};
    drive_run(4, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 6;
    if (cyc !== 5) begin failures++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
    if (accv40 !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", accv40); end
    if (acc40 !== 40'd29843 || acc40 !== e40[39:0]) begin failures++; $display("FAIL basic_acc40: got %0d expected 29843", acc40); end
    if (acc33 !== e33[32:0]) begin failures++; $display("FAIL basic_acc33: got %h expected %h", acc33, e33[32:0]); end
    if ({ovf40, ovf33} !== {o40, o33}) begin failures++; $display("FAIL basic_ovf: got %b%b expected %b%b", ovf40, ovf33, o40, o33); end
    if (ready40 !== 1'b0) begin failures++; $display("FAIL basic_ready_done: got %b expected 0", ready40); end
    accept();
    checks++;
    if (busy40 !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy %b expected 0", busy40); end
  endtask

  task automatic test_stalls();
    longint e40, e33;
    bit o40, o33, stable;
    logic [39:0] snap;
    int cyc;
    prods = '{5, 6, 7};
    drive_run(3, 2, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 4;
    if (cyc !== 8) begin failures++; $display("FAIL stall_latency: got %0d expected 8", cyc); end
    if (acc40 !== e40[39:0]) begin failures++; $display("FAIL stall_acc40: got %h expected %h", acc40, e40[39:0]); end
    if (acc33 !== e33[32:0]) begin failures++; $display("FAIL stall_acc33: got %h expected %h", acc33, e33[32:0]); end
    if ({ovf40, ovf33} !== {o40, o33}) begin failures++; $display("FAIL stall_ovf: got %b%b expected %b%b", ovf40, ovf33, o40, o33); end
    snap = acc40;
    stable = 1'b1;
    len_in = 8'd3;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      if (acc40 !== snap || accv40 !== 1'b1 || busy40 !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("FAIL hold_stable: got %b expected 1", stable); end
    start = 1'b1; acc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; acc_ready = 1'b0;
    checks++;
    if ({busy40, busy33, accv40} !== 3'b000) begin failures++; $display("FAIL accept_idle: got %b expected 000", {busy40, busy33, accv40}); end
    @(negedge clk);
    checks++;
    if ({busy40, ready40} !== 2'b00) begin failures++; $display("FAIL start_in_done_ignored: got %b expected 00", {busy40, ready40}); end
  endtask

  task automatic test_saturation();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    prods = {};
    for (int i = 0; i < 255; i++) prods.push_back(32'h7FFFFFFF);
    drive_run(255, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 6;
    if (cyc !== 256) begin failures++; $display("FAIL maxlen_latency: got %0d expected 256", cyc); end
    if (acc40 !== 40'd547608329985 || acc40 !== e40[39:0]) begin failures++; $display("FAIL maxlen_acc40: got %0d expected 547608329985", acc40); end
    if (ovf40 !== 1'b0 || ovf40 !== o40) begin failures++; $display("FAIL maxlen_ovf40: got %b expected 0", ovf40); end
    if (acc33 !== 33'h0FFFFFFFF || acc33 !== e33[32:0]) begin failures++; $display("FAIL pos_sat_acc33: got %h expected 0ffffffff", acc33); end
    if (ovf33 !== 1'b1 || ovf33 !== o33) begin failures++; $display("FAIL pos_sat_ovf33: got %b expected 1", ovf33); end
    if (accv33 !== 1'b1) begin failures++; $display("FAIL maxlen_valid33: got %b expected 1", accv33); end
    accept();
  endtask

  task automatic test_neg_saturation();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    prods = '{32'h80000000, 32'h80000000, 32'h80000000};
    drive_run(3, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 4;
    if (acc33 !== 33'h100000000 || acc33 !== e33[32:0]) begin failures++; $display("FAIL neg_sat_acc33: got %h expected 100000000", acc33); end
    if (ovf33 !== 1'b1 || ovf33 !== o33) begin failures++; $display("FAIL neg_sat_ovf33: got %b expected 1", ovf33); end
    if (acc40 !== e40[39:0]) begin failures++; $display("FAIL neg_acc40: got %h expected %h", acc40, e40[39:0]); end
    if (ovf40 !== o40) begin failures++; $display("FAIL neg_ovf40: got %b expected %b", ovf40, o40); end
    accept();
    prods = '{1};
    drive_run(1, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 3;
    if (acc33 !== 33'd1 || acc33 !== e33[32:0]) begin failures++; $display("FAIL clear_acc33: got %h expected 1", acc33); end
    if (ovf33 !== 1'b0 || ovf33 !== o33) begin failures++; $display("FAIL clear_ovf33: got %b expected 0", ovf33); end
    if (cyc !== 2) begin failures++; $display("FAIL len1_latency: got %0d expected 2", cyc); end
    accept();
  endtask

  task automatic test_zero_length();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    prods = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    drive_run(3, 0, cyc);
    void'(exp40_q.pop_front()); void'(exp33_q.pop_front());
    void'(ov40_q.pop_front());  void'(ov33_q.pop_front());
    accept();
    checks++;
    if (ready40 !== 1'b0) begin failures++; $display("FAIL zero_ready_idle: got %b expected 0", ready40); end
    drive_run(0, 0, cyc);
    e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
    o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
    checks += 5;
    if (cyc !== 1) begin failures++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
    if (accv40 !== 1'b1) begin failures++; $display("FAIL zero_valid: got %b expected 1", accv40); end
    if (acc40 !== e40[39:0] || acc33 !== e33[32:0]) begin failures++; $display("FAIL zero_acc: got %h/%h expected 0", acc40, acc33); end
    if ({ovf40, ovf33} !== {o40, o33}) begin failures++; $display("FAIL zero_ovf: got %b%b expected %b%b", ovf40, ovf33, o40, o33); end
    if (ready40 !== 1'b0) begin failures++; $display("FAIL zero_ready_done: got %b expected 0", ready40); end
    accept();
  endtask

  task automatic test_back_to_back();
    longint e40, e33;
    bit o40, o33;
    int cyc;
    for (int r = 0; r < 2; r++) begin
      prods = {};
      for (int i = 0; i < 6 - 2 * r; i++) prods.push_back(int'($urandom) >>> (r * 4));
      drive_run(6 - 2 * r, 0, cyc);
      e40 = exp40_q.pop_front(); e33 = exp33_q.pop_front();
      o40 = ov40_q.pop_front();  o33 = ov33_q.pop_front();
      checks += 4;
      if (cyc !== 7 - 2 * r) begin failures++; $display("FAIL b2b_latency%0d: got %0d expected %0d", r, cyc, 7 - 2 * r); end
      if (acc40 !== e40[39:0]) begin failures++; $display("FAIL b2b_acc40_%0d: got %h expected %h", r, acc40, e40[39:0]); end
      if (acc33 !== e33[32:0]) begin failures++; $display("FAIL b2b_acc33_%0d: got %h expected %h", r, acc33, e33[32:0]); end
      if ({ovf40, ovf33} !== {o40, o33}) begin failures++; $display("FAIL b2b_ovf%0d: got %b%b expected %b%b", r, ovf40, ovf33, o40, o33); end
      accept();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len_in = '0; product = '0;
    prod_valid = 1'b0; acc_ready = 1'b0;
    test_reset();
    test_basic();
    test_stalls();
    test_saturation();
    test_neg_saturation();
    test_zero_length();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
